add_process_pipe: RTL and testbench

//  Parametrised successor of the HCORDIC floating-point mantissa add stage, sitting between the align and normalise stages.

---
 rtl/add_process_pipe.sv | 194 +++++++++++++++++++
 tb/tb_add_process_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_process_pipe.sv
// Mantissa add/subtract stage between align and normalise: two registered stages
// (operand compare, then add) with a valid/ready handshake and a zero-result flag.
module add_process_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 27,
   parameter int BIAS  = 127,
   parameter int OP_W  = 4,
   parameter int TAG_W = 8,
   parameter int ZP_W  = 32
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_idle,
   input  logic                      in_sub,
   input  logic [OP_W-1:0]           in_opcode,
   input  logic [TAG_W-1:0]          in_tag,
   input  logic [ZP_W-1:0]           in_z_post,
   input  logic [EXP_W+MAN_W:0]      in_c,
   input  logic [EXP_W+MAN_W:0]      in_z,
   input  logic [EXP_W+MAN_W-4:0]    in_sout,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_idle,
   output logic [EXP_W+MAN_W-4:0]    out_sout,
   output logic [MAN_W:0]            out_sum,
   output logic                      out_zero,
   output logic [OP_W-1:0]           out_opcode,
   output logic [TAG_W-1:0]          out_tag,
   output logic [ZP_W-1:0]           out_z_post
);

   localparam int OPND_W = 1 + EXP_W + MAN_W;
   localparam int SOUT_W = 1 + EXP_W + MAN_W - 4;
   localparam int SUM_W  = MAN_W + 1;
   localparam int FRAC_W = MAN_W - 4;
   localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

   typedef struct packed {
      logic               idle;
      logic [OP_W-1:0]    opcode;
      logic [TAG_W-1:0]   tag;
      logic [ZP_W-1:0]    z_post;
      logic [SOUT_W-1:0]  sout;
      logic               c_sign;
      logic               zs_eff;
      logic [EXP_W-1:0]   exp_out;
      logic               eff_sub;
      logic               c_ge;
      logic [MAN_W-1:0]   c_man;
      logic [MAN_W-1:0]   z_man;
   } s1_t;

   typedef struct packed {
      logic               idle;
      logic [OP_W-1:0]    opcode;
      logic [TAG_W-1:0]   tag;
      logic [ZP_W-1:0]    z_post;
      logic [SOUT_W-1:0]  sout;
      logic [SUM_W-1:0]   sum;
      logic               zero;
   } s2_t;

   // Operand field decode; the z exponent is unused because operands arrive pre-aligned.
   logic               c_sign;
   logic               z_sign;
   logic               zs_eff;
   logic [EXP_W-1:0]   c_exp;
   logic [MAN_W-1:0]   c_man;
   logic [MAN_W-1:0]   z_man;
   logic               unused_z_exp;

   assign c_sign       = in_c[OPND_W-1];
   assign c_exp        = in_c[MAN_W +: EXP_W];
   assign c_man        = in_c[MAN_W-1:0];
   assign z_sign       = in_z[OPND_W-1];
   assign z_man        = in_z[MAN_W-1:0];
   assign zs_eff       = z_sign ^ in_sub;
   assign unused_z_exp = ^in_z[MAN_W +: EXP_W];

   // Handshake: a transfer happens on any edge where valid & ready are both high.
   // A stage loads when it is empty or its content moves on in the same cycle;
   // in_ready is combinational from out_ready, and flush wins over any load.
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s1_load, s2_load;
   logic s1_en, s2_en;

   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || (s2_load && s1_valid_q);
   assign in_ready = s1_load;
   assign s1_en    = s1_load && in_valid && !flush;
   assign s2_en    = s2_load && s1_valid_q && !flush;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (s1_load) s1_valid_d = in_valid;
         if (s2_load) s2_valid_d = s1_valid_q;
      end
   end

   // Stage 1: compare operands, unbias the exponent, capture side-band.
   s1_t s1_q, s1_d;

   always_comb begin
      s1_d = s1_q;
      if (s1_en) begin
         s1_d.idle    = in_idle;
         s1_d.opcode  = in_opcode;
         s1_d.tag     = in_tag;
         s1_d.z_post  = in_z_post;
         s1_d.sout    = in_sout;
         s1_d.c_sign  = c_sign;
         s1_d.zs_eff  = zs_eff;
         s1_d.exp_out = c_exp - BIAS_E;
         s1_d.eff_sub = c_sign != zs_eff;
         s1_d.c_ge    = c_man >= z_man;
         s1_d.c_man   = c_man;
         s1_d.z_man   = z_man;
      end
   end

   // Stage 2 arithmetic: magnitude add/subtract with carry kept for the normaliser.
   logic [SUM_W-1:0] sum_w;
   logic             sign_w;
   logic             zero_w;

   always_comb begin
      sum_w  = '0;
      sign_w = s1_q.c_sign;
      if (!s1_q.eff_sub) begin
         sum_w = {1'b0, s1_q.c_man} + {1'b0, s1_q.z_man};
      end else if (s1_q.c_ge) begin
         sum_w = {1'b0, s1_q.c_man} - {1'b0, s1_q.z_man};
      end else begin
         sum_w  = {1'b0, s1_q.z_man} - {1'b0, s1_q.c_man};
         sign_w = s1_q.zs_eff;
      end
      zero_w = (sum_w == '0);
      if (zero_w) sign_w = 1'b0;
   end

   s2_t s2_q, s2_d;

   always_comb begin
      s2_d = s2_q;
      if (s2_en) begin
         s2_d.idle   = s1_q.idle;
         s2_d.opcode = s1_q.opcode;
         s2_d.tag    = s1_q.tag;
         s2_d.z_post = s1_q.z_post;
         if (s1_q.idle) begin
            s2_d.sout = s1_q.sout;
            s2_d.sum  = '0;
            s2_d.zero = 1'b0;
         end else begin
            s2_d.sout = {sign_w, s1_q.exp_out, {FRAC_W{1'b0}}};
            s2_d.sum  = sum_w;
            s2_d.zero = zero_w;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_idle   = s2_q.idle;
   assign out_sout   = s2_q.sout;
   assign out_sum    = s2_q.sum;
   assign out_zero   = s2_q.zero;
   assign out_opcode = s2_q.opcode;
   assign out_tag    = s2_q.tag;
   assign out_z_post = s2_q.z_post;

endmodule

// File: tb/tb_add_process_pipe.sv
// Bench for add_process_pipe: directed cases, back-to-back stall, reset/flush and
// randomized traffic checked through an expected-result queue.
module tb_add_process_pipe;

   localparam int EXP_VW = 106;

   logic          clock;
   logic          reset_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          in_idle;
   logic          in_sub;
   logic [3:0]    in_opcode;
   logic [7:0]    in_tag;
   logic [31:0]   in_z_post;
   logic [35:0]   in_c;
   logic [35:0]   in_z;
   logic [31:0]   in_sout;
   logic          out_valid;
   logic          out_ready;
   logic          out_idle;
   logic [31:0]   out_sout;
   logic [27:0]   out_sum;
   logic          out_zero;
   logic [3:0]    out_opcode;
   logic [7:0]    out_tag;
   logic [31:0]   out_z_post;

   int errors = 0;
   int checks = 0;
   int out_count = 0;
   logic [EXP_VW-1:0] exp_q[$];

   add_process_pipe dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_idle(in_idle), .in_sub(in_sub),
      .in_opcode(in_opcode), .in_tag(in_tag), .in_z_post(in_z_post),
      .in_c(in_c), .in_z(in_z), .in_sout(in_sout),
      .out_valid(out_valid), .out_ready(out_ready), .out_idle(out_idle),
      .out_sout(out_sout), .out_sum(out_sum), .out_zero(out_zero),
      .out_opcode(out_opcode), .out_tag(out_tag), .out_z_post(out_z_post)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Reference model: signed sum of the two operands, then sign/magnitude split.
   function automatic logic [EXP_VW-1:0] model(input logic idle, input logic sub,
                                               input logic [3:0] op, input logic [7:0] tag,
                                               input logic [31:0] zp, input logic [35:0] c,
                                               input logic [35:0] z, input logic [31:0] so);
      longint cv, zv, r, mag;
      logic sgn;
      logic [7:0] e;
      logic [31:0] sv;
      if (idle) return {so, 28'd0, 1'b0, 1'b1, op, tag, zp};
      cv = longint'(c[26:0]);
      zv = longint'(z[26:0]);
      if (c[35]) cv = -cv;
      if (z[35] ^ sub) zv = -zv;
      r = cv + zv;
      sgn = (r < 0);
      mag = sgn ? -r : r;
      if (mag == 0) sgn = 1'b0;
      e = c[34:27] - 8'd127;
      sv = {sgn, e, 23'd0};
      return {sv, mag[27:0], (mag == 0), 1'b0, op, tag, zp};
   endfunction

   // scoreboard
   always @(negedge clock) begin
      if (reset_n && out_valid && out_ready) begin
         logic [EXP_VW-1:0] got;
         logic [EXP_VW-1:0] want;
         got = {out_sout, out_sum, out_zero, out_idle, out_opcode, out_tag, out_z_post};
         out_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected: got %h, required no output", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL scoreboard_result: got %h, required %h", got, want);
            end
         end
      end
   end

   // driver tasks
   task automatic send(input logic idle, input logic sub, input logic [3:0] op,
                       input logic [7:0] tag, input logic [31:0] zp,
                       input logic [35:0] c, input logic [35:0] z, input logic [31:0] so);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1; in_idle = idle; in_sub = sub; in_opcode = op; in_tag = tag;
      in_z_post = zp; in_c = c; in_z = z; in_sout = so;
      for (int k = 0; k < 60 && !acc; k++) begin
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         #1;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: tag %h never accepted, required acceptance", tag);
      end else begin
         exp_q.push_back(model(idle, sub, op, tag, zp, c, z, so));
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      checks++; if (out_sum !== 28'd0) begin errors++; $display("FAIL reset_out_sum: got %h, required 0", out_sum); end
      checks++; if (out_sout !== 32'd0) begin errors++; $display("FAIL reset_out_sout: got %h, required 0", out_sout); end
      checks++; if (out_tag !== 8'd0) begin errors++; $display("FAIL reset_out_tag: got %h, required 0", out_tag); end
      checks++; if ({out_zero, out_idle} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b, required 00", {out_zero, out_idle}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      send(1'b0, 1'b0, 4'h3, 8'h11, 32'h1234_5678, {1'b0, 8'h80, 27'h4000000}, {1'b0, 8'h80, 27'h2000000}, 32'h0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency1: out_valid %b, required 0", out_valid); end
      @(posedge clock); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency2: out_valid %b, required 1", out_valid); end
      checks++; if (out_sum !== 28'h6000000) begin errors++; $display("FAIL add_sum: got %h, required 6000000", out_sum); end
      checks++; if (out_sout !== 32'h00800000) begin errors++; $display("FAIL add_sout: got %h, required 00800000", out_sout); end
      checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b, required 0", out_zero); end
      @(posedge clock); #1;
   endtask

   task automatic test_mixed_sign();
      out_ready = 1'b1;
      send(1'b0, 1'b0, 4'h1, 8'h22, 32'h0, {1'b0, 8'h81, 27'h1000000}, {1'b1, 8'h81, 27'h3000000}, 32'h0);
      @(posedge clock); #1;
      checks++; if (out_sum !== 28'h2000000) begin errors++; $display("FAIL mixed_sum: got %h, required 2000000", out_sum); end
      checks++; if (out_sout[31] !== 1'b1) begin errors++; $display("FAIL mixed_sign: got %b, required 1", out_sout[31]); end
      checks++; if (out_sout[30:23] !== 8'h02) begin errors++; $display("FAIL mixed_exp: got %h, required 02", out_sout[30:23]); end
      @(posedge clock); #1;
   endtask

   task automatic test_zero();
      out_ready = 1'b1;
      send(1'b0, 1'b1, 4'h2, 8'h33, 32'h0, {1'b0, 8'h7F, 27'h5555555}, {1'b0, 8'h7F, 27'h5555555}, 32'hFFFF_FFFF);
      @(posedge clock); #1;
      checks++; if (out_sum !== 28'd0) begin errors++; $display("FAIL zero_sum: got %h, required 0", out_sum); end
      checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL zero_flag: got %b, required 1", out_zero); end
      checks++; if (out_sout !== 32'h0) begin errors++; $display("FAIL zero_sout: got %h, required 00000000", out_sout); end
      @(posedge clock); #1;
   endtask

   task automatic test_idle();
      out_ready = 1'b1;
      send(1'b1, 1'b0, 4'h7, 8'h5A, 32'hCAFE_0001, {1'b1, 8'h90, 27'h7FFFFFF}, {1'b0, 8'h10, 27'h1}, 32'hDEADBEEF);
      @(posedge clock); #1;
      checks++; if (out_sout !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_sout: got %h, required DEADBEEF", out_sout); end
      checks++; if (out_sum !== 28'd0) begin errors++; $display("FAIL idle_sum: got %h, required 0", out_sum); end
      checks++; if (out_tag !== 8'h5A) begin errors++; $display("FAIL idle_tag: got %h, required 5A", out_tag); end
      checks++; if ({out_idle, out_zero} !== 2'b10) begin errors++; $display("FAIL idle_flags: got %b, required 10", {out_idle, out_zero}); end
      @(posedge clock); #1;
   endtask

   task automatic test_back_to_back();
      int cnt0;
      logic [95:0] snap;
      cnt0 = out_count;
      out_ready = 1'b1;
      fork
         begin
            for (int t = 1; t <= 6; t++)
               send(1'b0, 1'b0, 4'h0, 8'(t), 32'(t * 3), {1'b0, 8'h85, 27'(t * 1000)}, {1'b0, 8'h85, 27'(t * 7)}, 32'h0);
         end
         begin
            repeat (2) @(posedge clock);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clock);
            @(negedge clock);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b, required 0", in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_held_valid: got %b, required 1", out_valid); end
            snap = {out_sout, out_sum, out_tag, out_z_post[27:0]};
            @(negedge clock);
            checks++;
            if ({out_sout, out_sum, out_tag, out_z_post[27:0]} !== snap) begin
               errors++; $display("FAIL b2b_hold_stable: got %h, required %h", {out_sout, out_sum, out_tag, out_z_post[27:0]}, snap);
            end
            @(posedge clock); #1 out_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (out_count - cnt0 != 6) begin errors++; $display("FAIL b2b_count: got %0d, required 6", out_count - cnt0); end
   endtask

   task automatic test_reset_flush();
      out_ready = 1'b0;
      send(1'b0, 1'b0, 4'h4, 8'hA1, 32'h0, {1'b0, 8'h80, 27'h10}, {1'b0, 8'h80, 27'h20}, 32'h0);
      send(1'b0, 1'b0, 4'h4, 8'hA2, 32'h0, {1'b0, 8'h80, 27'h30}, {1'b0, 8'h80, 27'h40}, 32'h0);
      @(negedge clock);
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL rst_full: got %b, required 10", {out_valid, in_ready}); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b, required 0", out_valid); end
      checks++; if (out_tag !== 8'h0 || out_sum !== 28'h0) begin errors++; $display("FAIL rst_async_data: tag %h sum %h, required 0 0", out_tag, out_sum); end
      exp_q.delete();
      @(posedge clock); #1 reset_n = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %b, required 0", out_valid); end

      send(1'b0, 1'b0, 4'h5, 8'hB1, 32'h0, {1'b0, 8'h80, 27'h100}, {1'b0, 8'h80, 27'h200}, 32'h0);
      send(1'b0, 1'b0, 4'h5, 8'hB2, 32'h0, {1'b0, 8'h80, 27'h300}, {1'b0, 8'h80, 27'h400}, 32'h0);
      // B1 leaves during the flush cycle; B2 and the new input must vanish.
      out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_tag = 8'hEE;
      @(posedge clock); #1;
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
      checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL flush_b1_emitted: queue %0d, required 1", exp_q.size()); end
      exp_q.delete();
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale: got %b at cycle %0d, required 0", out_valid, k); end
      end
      @(posedge clock); #1;
   endtask

   task automatic test_random();
      bit done;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [26:0] cm, zm;
               cm = 27'($urandom_range(0, 32'h7FF_FFFF));
               zm = ($urandom_range(0, 4) == 0) ? cm : 27'($urandom_range(0, 32'h7FF_FFFF));
               send(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    8'(i + 64), $urandom(),
                    {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), cm},
                    {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), zm}, $urandom());
            end
            done = 1'b1;
         end
         begin
            for (int k = 0; k < 2000 && !done; k++) begin
               @(posedge clock); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();
   endtask

   initial begin
      reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_idle = 1'b0; in_sub = 1'b0;
      in_opcode = '0; in_tag = '0; in_z_post = '0; in_c = '0; in_z = '0; in_sout = '0;
      out_ready = 1'b1;
      test_reset();
      test_add();
      test_mixed_sign();
      test_zero();
      test_idle();
      drain();
      test_back_to_back();
      test_reset_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
